hack_rom_loader: RTL

- Writes the instruction ROM that the Hack CPU fetches from, so it acts as the writer side of the CPU's instruction-read interface.
- Consumes a framed byte stream from an upstream byte source (UART receiver) and writes 16-bit instruction words into the ROM write port.
- Holds the CPU in reset while loading and releases it after a valid image is stored.
- Sits between the byte receiver, the instruction ROM write port and the CPU resetN input.

---
 rtl/hack_rom_loader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: receives a framed byte stream and writes 16-bit words into
// the Hack instruction ROM, holding the CPU in reset until a good image lands.
// Frame: A5, LEN_HI, LEN_LO, N words (high byte first), CHK (XOR of data bytes).
// Optional macro LOADER_STATUS_TX_EN adds a status byte transmitter
// (0x06 on a good load, 0x15 on an aborted or failed load).
module hack_rom_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter bit          RUN_ON_RESET   = 1'b0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        rom_we,
  output logic [14:0] rom_addr,
  output logic [15:0] rom_wdata,
  output logic        cpu_resetN,
  output logic        load_done,
`ifdef LOADER_STATUS_TX_EN
  output logic        load_err,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
`else
  output logic        load_err
`endif
);

  localparam int unsigned IDLE_W     = 20;
  localparam int unsigned WORD_CNT_W = 16;
  localparam int unsigned LEN_W      = 15;
  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR
  } state_t;

  state_t                  state;
  logic [IDLE_W-1:0]       idle_cnt;
  logic [WORD_CNT_W-1:0]   word_cnt;
  logic [LEN_W-1:0]        len;
  logic [6:0]              len_hi;
  logic [7:0]              hi_byte;
  logic [7:0]              chk;

  logic accept_c;
  logic active_c;
  logic timeout_c;
  logic go_err_c;
  logic go_done_c;

  // Decode the byte-transfer, timeout and frame-terminating events for this cycle
  always_comb begin
    accept_c  = rx_valid && rx_ready;
    active_c  = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI) ||
                (state == DATA_LO) || (state == CHECK);
    // An accepted byte always beats a timeout on the same cycle
    timeout_c = active_c && !accept_c &&
                (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
    go_err_c  = timeout_c ||
                (accept_c && (state == LEN_HI) && rx_data[7]) ||
                (accept_c && (state == CHECK) && (rx_data != chk));
    go_done_c = accept_c && (state == CHECK) && (rx_data == chk);
  end

  // Frame parser, ROM write port and status/CPU-reset outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      idle_cnt   <= '0;
      word_cnt   <= '0;
      len        <= '0;
      len_hi     <= '0;
      hi_byte    <= '0;
      chk        <= '0;
      rx_ready   <= 1'b0;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_wdata  <= '0;
      cpu_resetN <= RUN_ON_RESET;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      rx_ready <= 1'b1;
      rom_we   <= 1'b0;

      if (accept_c || !active_c || timeout_c) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end

      if (go_err_c) begin
        state    <= ERR;
        load_err <= 1'b1;
      end else if (go_done_c) begin
        state      <= DONE;
        load_done  <= 1'b1;
        cpu_resetN <= 1'b1;
      end else if (accept_c) begin
        case (state)
          IDLE, DONE, ERR: begin
            if (rx_data == SYNC_BYTE) begin
              state      <= LEN_HI;
              cpu_resetN <= 1'b0;
              load_done  <= 1'b0;
              load_err   <= 1'b0;
              word_cnt   <= '0;
              chk        <= '0;
            end
          end
          LEN_HI: begin
            len_hi <= rx_data[6:0];
            state  <= LEN_LO;
          end
          LEN_LO: begin
            len   <= {len_hi, rx_data};
            state <= ({len_hi, rx_data} == LEN_W'(0)) ? CHECK : DATA_HI;
          end
          DATA_HI: begin
            hi_byte <= rx_data;
            chk     <= chk ^ rx_data;
            state   <= DATA_LO;
          end
          DATA_LO: begin
            chk       <= chk ^ rx_data;
            rom_we    <= 1'b1;
            rom_addr  <= word_cnt[LEN_W-1:0];
            rom_wdata <= {hi_byte, rx_data};
            word_cnt  <= word_cnt + WORD_CNT_W'(1);
            state     <= ((word_cnt + WORD_CNT_W'(1)) == {1'b0, len}) ? CHECK : DATA_HI;
          end
          default: state <= state;
        endcase
      end
    end
  end

`ifdef LOADER_STATUS_TX_EN
  localparam logic [7:0] STATUS_ACK = 8'h06;
  localparam logic [7:0] STATUS_NAK = 8'h15;

  // Status byte: newest outcome overwrites a pending one, cleared once taken
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (go_done_c) begin
      tx_valid <= 1'b1;
      tx_data  <= STATUS_ACK;
    end else if (go_err_c) begin
      tx_valid <= 1'b1;
      tx_data  <= STATUS_NAK;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end
`endif

endmodule
